// File: rtl/sub8_pipe_pkg.sv
// Shared types and the 4-bit carry-lookahead helper for the pipelined 8-bit subtractor.
package sub_pkg;

    localparam int W   = 8;
    localparam int NIB = 4;

    typedef struct packed {
        logic bo;
        logic v;
        logic z;
    } flags_t;

    // Returns carries C[4:1] of a 4-bit group from propagate/generate terms.
    function automatic logic [3:0] lookahead4(input logic [3:0] p, input logic [3:0] g, input logic cin);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/sub8_pipe_if.sv
// Operand/result handshake bundle between an upstream producer, sub8_pipe and its consumer.
interface sub8_pipe_if;
    import sub_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         BI;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         BO;
    logic         V;
    logic         Z;

    modport master (
        output in_valid, X, Y, BI, out_ready,
        input  in_ready, out_valid, D, BO, V, Z
    );

    modport slave (
        input  in_valid, X, Y, BI, out_ready,
        output in_ready, out_valid, D, BO, V, Z
    );
endinterface

// File: rtl/sub8_pipe_cla4_nibble.sv
// One 4-bit carry-lookahead adder slice; subtraction is formed by the caller inverting B and Cin.
module cla4_nibble
    import sub_pkg::*;
(
    output logic [NIB-1:0] S,
    output logic           Cout,
    input  logic [NIB-1:0] A,
    input  logic [NIB-1:0] B,
    input  logic           Cin
);
    logic [NIB-1:0] w_p;
    logic [NIB-1:0] w_g;
    logic [NIB-1:0] w_c;

    assign w_p  = A ^ B;
    assign w_g  = A & B;
    assign w_c  = lookahead4(w_p, w_g, Cin);
    assign S    = w_p ^ {w_c[2:0], Cin};
    assign Cout = w_c[3];
endmodule

// File: rtl/sub8_pipe.sv
// Two-stage pipelined 8-bit subtractor D = X - Y - BI with registered borrow/overflow/zero flags.
module sub8_pipe
    import sub_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    sub8_pipe_if.slave  bus
);
    logic [NIB-1:0] r_dl;
    logic           r_c4;
    logic [NIB-1:0] r_xh;
    logic [NIB-1:0] r_nyh;
    logic           r_x7;
    logic           r_y7;
    logic           r_s1_v;

    logic [W-1:0]   r_d;
    flags_t         r_flags;
    logic           r_out_valid;

    logic [NIB-1:0] w_dl;
    logic           w_c4;
    logic [NIB-1:0] w_dh;
    logic           w_c8;
    logic [W-1:0]   w_d;
    flags_t         w_flags;
    logic           w_adv2;
    logic           w_in_ready;
    logic           w_take;

    assign w_adv2     = r_s1_v & (~r_out_valid | bus.out_ready);
    assign w_in_ready = ~rst & (~r_s1_v | w_adv2);
    assign w_take     = bus.in_valid & w_in_ready;

    cla4_nibble u_lo (
        .S    (w_dl),
        .Cout (w_c4),
        .A    (bus.X[NIB-1:0]),
        .B    (~bus.Y[NIB-1:0]),
        .Cin  (~bus.BI)
    );

    cla4_nibble u_hi (
        .S    (w_dh),
        .Cout (w_c8),
        .A    (r_xh),
        .B    (r_nyh),
        .Cin  (r_c4)
    );

    assign w_d = {w_dh, r_dl};

    // Flags for the result about to enter the output registers.
    always_comb begin
        w_flags    = '{bo: 1'b0, v: 1'b0, z: 1'b0};
        w_flags.bo = ~w_c8;
        w_flags.v  = (r_x7 ^ r_y7) & (w_d[W-1] ^ r_x7);
        w_flags.z  = ~|w_d;
    end

    // Stage 1: low-nibble difference plus the high-nibble operands it still needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_dl   <= {NIB{1'b0}};
            r_c4   <= 1'b0;
            r_xh   <= {NIB{1'b0}};
            r_nyh  <= {NIB{1'b0}};
            r_x7   <= 1'b0;
            r_y7   <= 1'b0;
        end else if (w_take) begin
            r_s1_v <= 1'b1;
            r_dl   <= w_dl;
            r_c4   <= w_c4;
            r_xh   <= bus.X[W-1:NIB];
            r_nyh  <= ~bus.Y[W-1:NIB];
            r_x7   <= bus.X[W-1];
            r_y7   <= bus.Y[W-1];
        end else if (w_adv2) begin
            r_s1_v <= 1'b0;
        end else begin
            r_s1_v <= r_s1_v;
        end
    end

    // Stage 2: result and flags, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_d         <= {W{1'b0}};
            r_flags     <= '{bo: 1'b0, v: 1'b0, z: 1'b0};
        end else if (w_adv2) begin
            r_out_valid <= 1'b1;
            r_d         <= w_d;
            r_flags     <= w_flags;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.D         = r_d;
    assign bus.BO        = r_flags.bo;
    assign bus.V         = r_flags.v;
    assign bus.Z         = r_flags.z;
endmodule

// File: tb/tb_sub8_pipe.sv
// Self-checking bench for sub8_pipe: directed cases, backpressure, random traffic, mid-flight reset.
module tb_sub8_pipe;
    import sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub8_pipe_if bus ();

    sub8_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    // Reference: {BO, V, Z, D} from integer arithmetic on the operands.
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int u;
        int s;
        logic [7:0] d;
        logic bo;
        logic v;
        logic z;
        u  = int'(x) - int'(y) - (bi ? 1 : 0);
        s  = int'($signed(x)) - int'($signed(y)) - (bi ? 1 : 0);
        d  = 8'(u);
        bo = (u < 0);
        v  = (s < -128) || (s > 127);
        z  = (d == 8'h00);
        return {bo, v, z, d};
    endfunction

    // Drive one cycle's inputs at the falling edge and sample what the next rising edge will see.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] x, input logic [7:0] y,
                         input logic bi, input logic ordy,
                         output logic took, output logic popped, output logic ir, output logic ov,
                         output logic [10:0] res);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.X         = x;
        bus.Y         = y;
        bus.BI        = bi;
        bus.out_ready = ordy;
        #1;
        ir     = bus.in_ready;
        ov     = bus.out_valid;
        res    = {bus.BO, bus.V, bus.Z, bus.D};
        took   = iv & ir;
        popped = ov & ordy;
    endtask

    task automatic test_reset();
        logic took, popped, ir, ov;
        logic [10:0] res;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, took, popped, ir, ov, res);
            checks++;
            if (ir !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready: got %b want 0", ir);
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0 || res !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b res=%h want ov=0 res=000", ov, res);
        end
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b want 1", ir);
        end
    endtask

    task automatic test_directed();
        logic [7:0] tx[6];
        logic [7:0] ty[6];
        logic       tb_bi[6];
        logic [10:0] texp[6];
        logic took, popped, ir, ov;
        logic [10:0] res;
        tx    = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h10, 8'h00};
        ty    = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h0F, 8'h00};
        tb_bi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        // {BO, V, Z, D}
        texp  = '{{3'b000, 8'h02}, {3'b100, 8'hFE}, {3'b010, 8'h7F},
                  {3'b110, 8'h80}, {3'b001, 8'h00}, {3'b100, 8'hFF}};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, tx[i], ty[i], tb_bi[i], 1'b1, took, popped, ir, ov, res);
            checks++;
            if (took !== 1'b1) begin
                errors++;
                $display("FAIL dir_accept[%0d]: got %b want 1", i, took);
            end
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL dir_early_valid[%0d]: got %b want 0", i, ov);
            end
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
            checks++;
            if (ov !== 1'b1 || res !== texp[i]) begin
                errors++;
                $display("FAIL dir_result[%0d]: got ov=%b res=%h want ov=1 res=%h", i, ov, res, texp[i]);
            end
            checks++;
            if (res !== model(tx[i], ty[i], tb_bi[i])) begin
                errors++;
                $display("FAIL dir_model[%0d]: got %h want %h", i, res, model(tx[i], ty[i], tb_bi[i]));
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
    endtask

    task automatic test_backpressure();
        logic took, popped, ir, ov;
        logic [10:0] res;
        logic [10:0] want[3];
        want = '{{3'b000, 8'h05}, {3'b001, 8'h00}, {3'b100, 8'hFF}};
        cycle(1'b0, 1'b1, 8'h09, 8'h04, 1'b0, 1'b0, took, popped, ir, ov, res);
        checks++;
        if (took !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b want 1", took); end
        cycle(1'b0, 1'b1, 8'h07, 8'h07, 1'b0, 1'b0, took, popped, ir, ov, res);
        checks++;
        if (took !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b want 1", took); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, took, popped, ir, ov, res);
            checks++;
            if (ir !== 1'b0 || ov !== 1'b1 || res !== want[0]) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ir=%b ov=%b res=%h want ir=0 ov=1 res=%h", i, ir, ov, res, want[0]);
            end
        end
        cycle(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (took !== 1'b1 || popped !== 1'b1 || res !== want[0]) begin
            errors++;
            $display("FAIL bp_release: got took=%b popped=%b res=%h want 1 1 %h", took, popped, res, want[0]);
        end
        for (int i = 1; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
            checks++;
            if (popped !== 1'b1 || res !== want[i]) begin
                errors++;
                $display("FAIL bp_order[%0d]: got popped=%b res=%h want 1 %h", i, popped, res, want[i]);
            end
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL bp_drained: got ov=%b want 0", ov); end
    endtask

    task automatic test_random();
        logic took, popped, ir, ov;
        logic [10:0] res;
        logic [10:0] front;
        logic [7:0] x, y;
        logic iv, bi, ordy;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            x    = 8'($urandom);
            y    = 8'($urandom);
            bi   = 1'($urandom);
            cycle(1'b0, iv, x, y, bi, ordy, took, popped, ir, ov, res);
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious: got res=%h with no pending operand", res);
                end else begin
                    front = exp_q.pop_front();
                    if (res !== front) begin
                        errors++;
                        $display("FAIL rnd_result: got %h want %h", res, front);
                    end
                end
            end
            if (took) begin
                exp_q.push_back(model(x, y, bi));
                checks++;
                if (exp_q.size() > 2) begin
                    errors++;
                    $display("FAIL rnd_capacity: got %0d pending want <=2", exp_q.size());
                end
            end
        end
        for (int n = 0; n < 8 && exp_q.size() != 0; n++) begin
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
            if (popped) begin
                front = exp_q.pop_front();
                checks++;
                if (res !== front) begin
                    errors++;
                    $display("FAIL rnd_drain: got %h want %h", res, front);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost: got %0d results missing want 0", exp_q.size());
            exp_q.delete();
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL rnd_idle: got ov=%b want 0", ov); end
    endtask

    task automatic test_reset_midflight();
        logic took, popped, ir, ov;
        logic [10:0] res;
        logic [10:0] want;
        cycle(1'b0, 1'b1, 8'h20, 8'h01, 1'b0, 1'b0, took, popped, ir, ov, res);
        cycle(1'b0, 1'b1, 8'h30, 8'h02, 1'b0, 1'b0, took, popped, ir, ov, res);
        cycle(1'b1, 1'b1, 8'h44, 8'h11, 1'b0, 1'b0, took, popped, ir, ov, res);
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", ir); end
        cycle(1'b0, 1'b1, 8'h55, 8'h15, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0 || res !== 11'h000) begin
            errors++;
            $display("FAIL mid_rst_clear: got ov=%b res=%h want ov=0 res=000", ov, res);
        end
        checks++;
        if (took !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", took); end
        want = model(8'h55, 8'h15, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL mid_stale: got ov=%b res=%h want ov=0", ov, res); end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b1 || res !== want) begin
            errors++;
            $display("FAIL mid_result: got ov=%b res=%h want ov=1 res=%h", ov, res, want);
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, took, popped, ir, ov, res);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL mid_dup: got ov=%b want 0", ov); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.X         = 8'h00;
        bus.Y         = 8'h00;
        bus.BI        = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
